// File: rtl/sync_fork_pkg.sv
// Shared types for the clocked 4-phase fork/merge handshake stages.
// FSM state encoding is fixed so the merge stage can reuse it.
package sync_fork_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      REL  = 2'd3
   } state_t;

   localparam int MIN_SYNC_STAGES = 2;

   // States in which the FSM is blocked on the consumers' acknowledges
   function automatic logic is_waiting(input state_t s);
      return (s == REQ) || (s == REL);
   endfunction

endpackage

// File: rtl/sync_fork_nffsync.sv
// N-flop synchroniser bringing an asynchronous level into the clk domain.
module nffsync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in,
   output logic out_r
);

   logic [SYNC_STAGES-1:0] sr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sr <= '0;
      else          sr <= {sr[SYNC_STAGES-2:0], in};
   end

   assign out_r = sr[SYNC_STAGES-1];

endmodule

// File: rtl/sync_fork.sv
// Clocked 4-phase fork: one requester fanned out to two consumers, completing on both acks.
// Optional watchdog (sticky err) is compiled in with SYNC_FORK_TIMEOUT_EN.
module sync_fork
   import sync_fork_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TIMEOUT_W      = 11
) (
   input  logic clk,
   input  logic reset_n,
   input  logic r0,
   output logic a0,
   output logic r1,
   input  logic a1,
   output logic r2,
   input  logic a2,
   output logic r0_r,
   output logic a1_r,
   output logic a2_r,
   output logic busy,
   output logic err
);

   if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
      $error("sync_fork: SYNC_STAGES must be >= 2");
   end
   if ((2 ** TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_bad_tmo
      $error("sync_fork: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
   end

   nffsync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_r0 (.clk(clk), .reset_n(reset_n), .in(r0), .out_r(r0_r));
   nffsync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a1 (.clk(clk), .reset_n(reset_n), .in(a1), .out_r(a1_r));
   nffsync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a2 (.clk(clk), .reset_n(reset_n), .in(a2), .out_r(a2_r));

   state_t state;
   logic   advance;

   // Leaving the current state this edge; the join needs both acks in the same sample
   always_comb begin
      advance = 1'b0;
      case (state)
         IDLE: advance = r0_r;
         REQ:  advance = a1_r & a2_r;
         ACK:  advance = ~r0_r;
         REL:  advance = ~a1_r & ~a2_r;
         default: advance = 1'b0;
      endcase
   end

   // Outputs are loaded together with the next state so they never decode glitches
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         r1    <= 1'b0;
         r2    <= 1'b0;
         a0    <= 1'b0;
         busy  <= 1'b0;
      end else if (advance) begin
         case (state)
            IDLE: begin
               state <= REQ;
               r1    <= 1'b1;
               r2    <= 1'b1;
               busy  <= 1'b1;
            end
            REQ: begin
               state <= ACK;
               a0    <= 1'b1;
            end
            ACK: begin
               state <= REL;
               r1    <= 1'b0;
               r2    <= 1'b0;
            end
            default: begin
               state <= IDLE;
               a0    <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SYNC_FORK_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_W-1:0] cnt;

   // Watchdog only flags the stall; the handshake is left to finish on its own
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (advance || !is_waiting(state)) begin
         cnt <= '0;
      end else if (cnt == TMO_LAST) begin
         err <= 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule
